// File: rtl/channel_arbiter.sv
// channel_arbiter
//   Round-robin arbiter and burst sequencer for one output port of the
//   routing switch. It picks one requesting input port, drives the
//   channel_mux select one-hot, and then holds that grant for exactly one
//   BURST-flit packet, stalling whenever READY is low. One IDLE cycle
//   always separates bursts, and the next search starts just past the
//   last winner.
//
// Parameters
//   Numports  number of input ports competing for this output
//   PortNo    index of the output port served (informational only)
//   BURST     flits per packet, 1..256
//
// Ports
//   CLK    clock, rising edge
//   RST    asynchronous active-high reset
//   REQ    per-input-port request
//   READY  downstream accepts the current flit this cycle
//   SEL    one-hot mux select, zero while idle
//   GNT    one-cycle one-hot grant pulse in the first transfer cycle
//   VALID  current flit is valid
//   FLIT   index of the current flit within the burst, zero-extended
//   LAST   final flit of the burst is on the output
//   BUSY   a burst is in progress
module channel_arbiter #(
  parameter int Numports = 4,
  parameter int PortNo   = 1,
  parameter int BURST    = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [Numports-1:0] REQ,
  input  logic                READY,
  output logic [Numports-1:0] SEL,
  output logic [Numports-1:0] GNT,
  output logic                VALID,
  output logic [7:0]          FLIT,
  output logic                LAST,
  output logic                BUSY
);

  localparam int FW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int PW = (Numports > 1) ? $clog2(Numports) : 1;

  localparam logic [FW-1:0] FLIT_LAST = FW'(BURST - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(Numports - 1);
  localparam logic [PW:0]   PORTS     = (PW + 1)'(Numports);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]          state;
  logic [Numports-1:0] sel_q;
  logic [Numports-1:0] gnt_q;
  logic [FW-1:0]       flit_q;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       win_q;

  // Search logic: rotate REQ so the bit at PTR lands in position 0, take the
  // lowest set bit, then map the offset back to an absolute port number.
  logic [2*Numports-1:0] req_dbl;
  logic [Numports-1:0]   req_rot;
  logic                  found;
  logic [PW:0]           idx_sum;
  logic [PW-1:0]         win_next;

  assign req_dbl = {REQ, REQ} >> ptr_q;
  assign req_rot = req_dbl[Numports-1:0];

  // NOTE: every variable assigned here gets a default first, so no path
  // through the block leaves it holding its old value (which would be a latch).
  always_comb begin
    found    = 1'b0;
    win_next = '0;
    idx_sum  = '0;
    for (int k = 0; k < Numports; k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        idx_sum = {1'b0, ptr_q} + (PW + 1)'(k);
        // Wrap by compare: Numports need not be a power of two.
        if (idx_sum >= PORTS) begin
          idx_sum = idx_sum - PORTS;
        end
        win_next = idx_sum[PW-1:0];
      end
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      sel_q  <= '0;
      gnt_q  <= '0;
      flit_q <= '0;
      ptr_q  <= '0;
      win_q  <= '0;
    end else begin
      gnt_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state  <= XFER;
            sel_q  <= Numports'(1) << win_next;
            gnt_q  <= Numports'(1) << win_next;
            win_q  <= win_next;
            flit_q <= '0;
          end
        end
        XFER: begin
          // REQ is deliberately ignored here: the burst always completes.
          if (READY) begin
            if (flit_q == FLIT_LAST) begin
              state  <= IDLE;
              sel_q  <= '0;
              flit_q <= '0;
              ptr_q  <= (win_q == PTR_LAST) ? '0 : win_q + PW'(1);
            end else begin
              flit_q <= flit_q + FW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          sel_q <= '0;
        end
      endcase
    end
  end

  assign SEL   = sel_q;
  assign GNT   = gnt_q;
  assign VALID = (state == XFER);
  assign BUSY  = (state == XFER);
  assign FLIT  = 8'(flit_q);
  assign LAST  = VALID && (flit_q == FLIT_LAST);

  sel_gnt_onehot : assert property (@(posedge CLK) disable iff (RST)
      $onehot0(SEL) && $onehot0(GNT))
    else $error("output port %0d: SEL/GNT not one-hot (SEL=%b GNT=%b)", PortNo, SEL, GNT);

endmodule

// File: tb/tb_channel_arbiter.sv
// Directed bench for channel_arbiter (Numports=4, BURST=8). Inputs change
// 1 ns after each rising edge and outputs are checked at the same point, so
// every check sees the registered result of the preceding edge.
module tb_channel_arbiter;

  localparam int NP = 4;
  localparam int BL = 8;

  logic          CLK;
  logic          RST;
  logic [NP-1:0] REQ;
  logic          READY;
  logic [NP-1:0] SEL;
  logic [NP-1:0] GNT;
  logic          VALID;
  logic [7:0]    FLIT;
  logic          LAST;
  logic          BUSY;

  int vectors;
  int miscompares;

  channel_arbiter #(.Numports(NP), .PortNo(1), .BURST(BL)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .READY (READY),
    .SEL   (SEL),
    .GNT   (GNT),
    .VALID (VALID),
    .FLIT  (FLIT),
    .LAST  (LAST),
    .BUSY  (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Observed/expected packed as {SEL, GNT, VALID, FLIT, LAST, BUSY}.
  task automatic check(input string tag, input logic [18:0] expv);
    logic [18:0] obs;
    obs = {SEL, GNT, VALID, FLIT, LAST, BUSY};
    vectors++;
    assert (obs === expv)
      else begin
        miscompares++;
        $error("FAIL %s: observed SEL=%b GNT=%b VALID=%b FLIT=%0d LAST=%b BUSY=%b, expected SEL=%b GNT=%b VALID=%b FLIT=%0d LAST=%b BUSY=%b",
               tag, obs[18:15], obs[14:11], obs[10], obs[9:2], obs[1], obs[0],
               expv[18:15], expv[14:11], expv[10], expv[9:2], expv[1], expv[0]);
      end
  endtask

  task automatic exp_idle(input string tag);
    check(tag, 19'd0);
  endtask

  task automatic exp_xfer(input string tag, input int port, input bit first, input int flit);
    logic [NP-1:0] oh;
    logic [7:0]    f;
    oh = NP'(1) << port;
    f  = 8'(flit);
    check(tag, {oh, first ? oh : 4'b0000, 1'b1, f, (flit == BL - 1), 1'b1});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST   = 1'b1;
    REQ   = '0;
    READY = 1'b1;

    // Reset state before any clock edge.
    #2;
    exp_idle("reset_async");
    tick();
    tick();
    RST = 1'b0;

    // No requests: stays idle.
    for (int c = 0; c < 10; c++) begin
      tick();
      exp_idle($sformatf("idle_c%0d", c));
    end

    // Single requester, port 1, full burst with READY high.
    REQ = 4'b0010;
    tick();
    exp_xfer("single_grant", 1, 1'b1, 0);
    REQ = 4'b0000;
    for (int f = 1; f < BL; f++) begin
      tick();
      exp_xfer($sformatf("single_f%0d", f), 1, 1'b0, f);
    end
    tick();
    exp_idle("single_done");

    // Re-reset asynchronously so the pointer restarts at 0.
    #2;
    RST = 1'b1;
    #1;
    exp_idle("rst_pulse");
    RST = 1'b0;

    // All four requesting continuously: grant order 0,1,2,3,0.
    REQ = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      tick();
      exp_xfer($sformatf("rr_b%0d_grant", b), b % NP, 1'b1, 0);
      for (int f = 1; f < BL; f++) begin
        tick();
        exp_xfer($sformatf("rr_b%0d_f%0d", b, f), b % NP, 1'b0, f);
      end
      tick();
      exp_idle($sformatf("rr_b%0d_gap", b));
    end
    REQ = 4'b0000;

    // Port 1 with a 3-cycle READY stall at flit 3 (pointer now 1).
    REQ = 4'b0010;
    tick();
    exp_xfer("stall_grant", 1, 1'b1, 0);
    REQ = 4'b0000;
    for (int f = 1; f <= 3; f++) begin
      tick();
      exp_xfer($sformatf("stall_pre_f%0d", f), 1, 1'b0, f);
    end
    READY = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      exp_xfer($sformatf("stall_hold%0d", s), 1, 1'b0, 3);
    end
    READY = 1'b1;
    for (int f = 4; f < BL; f++) begin
      tick();
      exp_xfer($sformatf("stall_post_f%0d", f), 1, 1'b0, f);
    end
    tick();
    exp_idle("stall_done");

    // Pointer now 2; only port 1 requests, so it still wins. REQ[1] drops at
    // flit 2 while REQ[2] rises: burst completes, then port 2 is granted.
    REQ = 4'b0010;
    tick();
    exp_xfer("ign_grant", 1, 1'b1, 0);
    tick();
    exp_xfer("ign_f1", 1, 1'b0, 1);
    tick();
    exp_xfer("ign_f2", 1, 1'b0, 2);
    REQ = 4'b0100;
    for (int f = 3; f < BL; f++) begin
      tick();
      exp_xfer($sformatf("ign_f%0d", f), 1, 1'b0, f);
    end
    tick();
    exp_idle("ign_gap");
    tick();
    exp_xfer("ign_next_grant", 2, 1'b1, 0);
    REQ = 4'b0000;

    // Reset mid-burst at flit 4: outputs clear before the next edge.
    for (int f = 1; f <= 4; f++) begin
      tick();
      exp_xfer($sformatf("abort_f%0d", f), 2, 1'b0, f);
    end
    #2;
    RST = 1'b1;
    #1;
    exp_idle("abort_async");
    REQ = 4'b1010;
    tick();
    exp_idle("abort_held");
    #2;
    RST = 1'b0;

    // Pointer reset to 0: search 0,1 finds port 1 ahead of port 3.
    tick();
    exp_xfer("post_rst_grant", 1, 1'b1, 0);
    REQ = 4'b1000;
    for (int f = 1; f < BL; f++) begin
      tick();
      exp_xfer($sformatf("post_rst_f%0d", f), 1, 1'b0, f);
    end
    tick();
    exp_idle("post_rst_gap");
    tick();
    exp_xfer("post_rst_port3", 3, 1'b1, 0);
    REQ = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
